cp0_nway: RTL and testbench

//  Parametrised CP0 for the N-way superscalar pipeline. Holds BadVAddr/Count/Compare/Status/Cause/EPC,

---
 rtl/cp0_nway_if.sv | 32 +++
 rtl/cp0_nway.sv | 224 ++++++++++++++++++++++
 tb/tb_cp0_nway.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cp0_nway_if.sv
// Pipeline <-> CP0 bundle for the N-way core: EX reads and exception reports, WB writes,
// external interrupt lines, and the flush/redirect results returned to the front end.
interface cp0_nway_if #(
    parameter int WAYS     = 2,
    parameter int HW_INT_W = 6
);
    logic [WAYS-1:0]      ex_cp0_re;
    logic [5*WAYS-1:0]    ex_cp0_raddr;
    logic [32*WAYS-1:0]   ex_cp0_rdata;
    logic [WAYS-1:0]      wb_cp0_we;
    logic [5*WAYS-1:0]    wb_cp0_waddr;
    logic [32*WAYS-1:0]   wb_cp0_wdata;
    logic [HW_INT_W-1:0]  int_i;
    logic [32*WAYS-1:0]   ex_cp0_exc_pc;
    logic [WAYS-1:0]      ex_cp0_in_delay;
    logic [5*WAYS-1:0]    ex_cp0_exc_code;
    logic                 exc_flush_all;
    logic                 exc_flush_icache;
    logic [31:0]          cp0_if_excaddr;

    modport master (
        output ex_cp0_re, ex_cp0_raddr, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, int_i,
               ex_cp0_exc_pc, ex_cp0_in_delay, ex_cp0_exc_code,
        input  ex_cp0_rdata, exc_flush_all, exc_flush_icache, cp0_if_excaddr
    );

    modport slave (
        input  ex_cp0_re, ex_cp0_raddr, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, int_i,
               ex_cp0_exc_pc, ex_cp0_in_delay, ex_cp0_exc_code,
        output ex_cp0_rdata, exc_flush_all, exc_flush_icache, cp0_if_excaddr
    );
endinterface

// File: rtl/cp0_nway.sv
// CP0 for the N-way superscalar pipeline: BadVAddr/Count/Compare/Status/Cause/EPC, exception
// arbitration, flush and redirect. Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_nway #(
    parameter int          WAYS     = 2,
    parameter int          HW_INT_W = 6,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380,
    parameter int          SYNC_ST  = 2
) (
    input logic       clk,
    input logic       rst_,
    cp0_nway_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_NONE = 5'h10;
    localparam logic [4:0] CODE_ERET = 5'h11;

    logic [31:0]         badvaddr_q, badvaddr_d;
    logic [31:0]         epc_q, epc_d, epc_fwd;
    logic [7:0]          status_im_q, status_im_d;
    logic                status_exl_q, status_exl_d;
    logic                status_ie_q, status_ie_d;
    logic                cause_bd_q, cause_bd_d;
    logic [1:0]          cause_sw_q, cause_sw_d;
    logic [4:0]          cause_code_q, cause_code_d;
    logic [HW_INT_W-1:0] ip_hw_q;
    logic [HW_INT_W-1:0] sync_q [SYNC_ST];
    logic                flush_icache_q;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        tick_q;
    logic        compare_wr;
`endif

    logic [5:0]  ip_hw_ext;
    logic        ti_bit;
    logic [7:0]  cause_ip;
    logic [31:0] status_val, cause_val;
    logic        int_pending;
    logic        win_valid, win_bd, take_exc, take_eret;
    logic [4:0]  win_code;
    logic [31:0] win_pc, wd;

    always_comb begin
        ip_hw_ext = '0;
        ip_hw_ext[HW_INT_W-1:0] = ip_hw_q;
    end

`ifdef CP0_TIMER_EN
    assign ti_bit = ti_q;
`else
    assign ti_bit = 1'b0;
`endif

    assign cause_ip    = {ip_hw_ext[5] | ti_bit, ip_hw_ext[4:0], cause_sw_q};
    assign status_val  = {16'h0, status_im_q, 6'h0, status_exl_q, status_ie_q};
    assign cause_val   = {cause_bd_q, ti_bit, 14'h0, cause_ip, 1'b0, cause_code_q, 2'b00};
    assign int_pending = (|(status_im_q & cause_ip)) & status_ie_q & ~status_exl_q;

    // Interrupt claims way 0; otherwise the oldest way reporting anything wins.
    always_comb begin
        win_valid = 1'b0;
        win_code  = CODE_NONE;
        win_pc    = '0;
        win_bd    = 1'b0;
        if (int_pending) begin
            win_valid = 1'b1;
            win_code  = CODE_INT;
            win_pc    = bus.ex_cp0_exc_pc[31:0];
            win_bd    = bus.ex_cp0_in_delay[0];
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (!win_valid && bus.ex_cp0_exc_code[5*w +: 5] != CODE_NONE) begin
                    win_valid = 1'b1;
                    win_code  = bus.ex_cp0_exc_code[5*w +: 5];
                    win_pc    = bus.ex_cp0_exc_pc[32*w +: 32];
                    win_bd    = bus.ex_cp0_in_delay[w];
                end
            end
        end
    end

    assign take_exc  = win_valid && (win_code != CODE_ERET);
    assign take_eret = win_valid && (win_code == CODE_ERET);

    always_comb begin
        bus.ex_cp0_rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.ex_cp0_re[w]) begin
                case (bus.ex_cp0_raddr[5*w +: 5])
                    REG_BADVADDR: bus.ex_cp0_rdata[32*w +: 32] = badvaddr_q;
`ifdef CP0_TIMER_EN
                    REG_COUNT:    bus.ex_cp0_rdata[32*w +: 32] = count_q;
                    REG_COMPARE:  bus.ex_cp0_rdata[32*w +: 32] = compare_q;
`endif
                    REG_STATUS:   bus.ex_cp0_rdata[32*w +: 32] = status_val;
                    REG_CAUSE:    bus.ex_cp0_rdata[32*w +: 32] = cause_val;
                    REG_EPC:      bus.ex_cp0_rdata[32*w +: 32] = epc_q;
                    default:      ;
                endcase
            end
        end
    end

    // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        badvaddr_d   = badvaddr_q;
        epc_d        = epc_q;
        status_im_d  = status_im_q;
        status_exl_d = status_exl_q;
        status_ie_d  = status_ie_q;
        cause_bd_d   = cause_bd_q;
        cause_sw_d   = cause_sw_q;
        cause_code_d = cause_code_q;
        wd           = '0;
`ifdef CP0_TIMER_EN
        count_d    = tick_q ? count_q + 32'd1 : count_q;
        compare_d  = compare_q;
        compare_wr = 1'b0;
        ti_d       = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
`endif
        // WB instructions are older than anything in EX, so their writes always land; ways
        // are walked low to high so the youngest writer of a register wins.
        for (int w = 0; w < WAYS; w++) begin
            if (bus.wb_cp0_we[w]) begin
                wd = bus.wb_cp0_wdata[32*w +: 32];
                case (bus.wb_cp0_waddr[5*w +: 5])
                    REG_BADVADDR: badvaddr_d = wd;
`ifdef CP0_TIMER_EN
                    REG_COUNT:    count_d = wd;
                    REG_COMPARE: begin
                        compare_d  = wd;
                        compare_wr = 1'b1;
                    end
`endif
                    REG_STATUS: begin
                        status_im_d  = wd[15:8];
                        status_exl_d = wd[1];
                        status_ie_d  = wd[0];
                    end
                    REG_CAUSE:    cause_sw_d = wd[9:8];
                    REG_EPC:      epc_d = wd;
                    default:      ;
                endcase
            end
        end
`ifdef CP0_TIMER_EN
        if (compare_wr) ti_d = 1'b0;
`endif
        epc_fwd = epc_d;

        if (take_exc) begin
            // A nested exception keeps the original return point.
            if (!status_exl_q) begin
                epc_d      = win_bd ? win_pc - 32'd4 : win_pc;
                cause_bd_d = win_bd;
            end
            status_exl_d = 1'b1;
            cause_code_d = win_code;
            if (win_code == CODE_ADEL || win_code == CODE_ADES) badvaddr_d = win_pc;
        end else if (take_eret) begin
            status_exl_d = 1'b0;
        end
    end

    assign bus.exc_flush_all    = win_valid & rst_;
    assign bus.exc_flush_icache = flush_icache_q;
    assign bus.cp0_if_excaddr   = !(win_valid & rst_) ? 32'd0 :
                                  take_eret           ? epc_fwd : EXC_VEC;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            badvaddr_q     <= '0;
            epc_q          <= '0;
            status_im_q    <= 8'hFF;
            status_exl_q   <= 1'b0;
            status_ie_q    <= 1'b1;
            cause_bd_q     <= 1'b0;
            cause_sw_q     <= '0;
            cause_code_q   <= '0;
            ip_hw_q        <= '0;
            flush_icache_q <= 1'b0;
            // NOTE: the synchroniser array is a few flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < SYNC_ST; i++) sync_q[i] <= '0;
`ifdef CP0_TIMER_EN
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            tick_q    <= 1'b0;
`endif
        end else begin
            badvaddr_q     <= badvaddr_d;
            epc_q          <= epc_d;
            status_im_q    <= status_im_d;
            status_exl_q   <= status_exl_d;
            status_ie_q    <= status_ie_d;
            cause_bd_q     <= cause_bd_d;
            cause_sw_q     <= cause_sw_d;
            cause_code_q   <= cause_code_d;
            ip_hw_q        <= sync_q[SYNC_ST-1];
            flush_icache_q <= win_valid;
            sync_q[0]      <= bus.int_i;
            for (int i = 1; i < SYNC_ST; i++) sync_q[i] <= sync_q[i-1];
`ifdef CP0_TIMER_EN
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            tick_q    <= ~tick_q;
`endif
        end
    end
endmodule

// File: tb/tb_cp0_nway.sv
// Directed bench for cp0_nway (WAYS=2): vector table for exception/ERET/MTC0 behaviour,
// plus sequences for interrupt latency, asynchronous reset and, with CP0_TIMER_EN, the timer.
module tb_cp0_nway;
    logic clk = 1'b0;
    logic rst_;
    int   checks = 0;
    int   errors = 0;

    cp0_nway_if #(.WAYS(2), .HW_INT_W(6)) bus ();

    cp0_nway #(
        .WAYS(2), .HW_INT_W(6), .EXC_VEC(32'hBFC00380), .SYNC_ST(2)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code0, code1;
        logic [31:0] pc0, pc1;
        logic        dly0, dly1;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        exp_flush;
        logic [31:0] exp_addr, exp_epc, exp_cause, exp_status, exp_badv;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.ex_cp0_re       = '0;
        bus.ex_cp0_raddr    = '0;
        bus.wb_cp0_we       = '0;
        bus.wb_cp0_waddr    = '0;
        bus.wb_cp0_wdata    = '0;
        bus.ex_cp0_exc_pc   = '0;
        bus.ex_cp0_in_delay = '0;
        bus.ex_cp0_exc_code = {5'h10, 5'h10};
    endtask

    task automatic rd(input int w, input logic [4:0] a, output logic [31:0] d);
        bus.ex_cp0_re    = '0;
        bus.ex_cp0_raddr = '0;
        bus.ex_cp0_re[w] = 1'b1;
        bus.ex_cp0_raddr[5*w +: 5] = a;
        #1;
        d = bus.ex_cp0_rdata[32*w +: 32];
        bus.ex_cp0_re = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.ex_cp0_exc_code = {v.code1, v.code0};
        bus.ex_cp0_exc_pc   = {v.pc1, v.pc0};
        bus.ex_cp0_in_delay = {v.dly1, v.dly0};
        bus.wb_cp0_we       = {v.we1, v.we0};
        bus.wb_cp0_waddr    = {v.wa1, v.wa0};
        bus.wb_cp0_wdata    = {v.wd1, v.wd0};
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                code0  code1  pc0           pc1           d0    d1    we0   wa0    wd0           we1   wa1    wd1           flush addr          epc           cause         status        badv
        vecs[0]  = '{5'h10, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0000FF01, 32'h0};
        vecs[1]  = '{5'h10, 5'h08, 32'h0,        32'hBFC00104, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC00380, 32'hBFC00104, 32'h00000020, 32'h0000FF03, 32'h0};
        vecs[2]  = '{5'h11, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC00104, 32'hBFC00104, 32'h00000020, 32'h0000FF01, 32'h0};
        vecs[3]  = '{5'h04, 5'h0C, 32'h80000002, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC00380, 32'h7FFFFFFE, 32'h80000010, 32'h0000FF03, 32'h80000002};
        vecs[4]  = '{5'h10, 5'h0A, 32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC00380, 32'h7FFFFFFE, 32'h80000028, 32'h0000FF03, 32'h80000002};
        vecs[5]  = '{5'h11, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'h80001000, 1'b1, 32'h80001000, 32'h80001000, 32'h80000028, 32'h0000FF01, 32'h80000002};
        vecs[6]  = '{5'h10, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd8,  32'h11111111, 1'b1, 5'd8,  32'h22222222, 1'b0, 32'h0,        32'h80001000, 32'h80000028, 32'h0000FF01, 32'h22222222};
        vecs[7]  = '{5'h10, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd12, 32'hFFFFAA01, 1'b1, 5'd13, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80001000, 32'h80000328, 32'h0000AA01, 32'h22222222};
        vecs[8]  = '{5'h10, 5'h10, 32'h00400000, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC00380, 32'h00400000, 32'h00000300, 32'h0000AA03, 32'h22222222};
        vecs[9]  = '{5'h10, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd13, 32'h0,        1'b1, 5'd12, 32'h0000FF01, 1'b0, 32'h0,        32'h00400000, 32'h0,        32'h0000FF01, 32'h22222222};
        vecs[10] = '{5'h10, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd3,  32'hFFFFFFFF, 1'b1, 5'd14, 32'hCAFEBABE, 1'b0, 32'h0,        32'hCAFEBABE, 32'h0,        32'h0000FF01, 32'h22222222};
        vecs[11] = '{5'h11, 5'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd14, 32'h11110000, 1'b1, 5'd14, 32'h22220000, 1'b1, 32'h22220000, 32'h22220000, 32'h0,        32'h0000FF01, 32'h22222222};

        rst_ = 1'b0;
        idle();
        bus.int_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flush", {31'd0, bus.exc_flush_all}, 32'd0);
        rd(0, 5'd12, d); check("reset_status", d, 32'h0000FF01);
        rst_ = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_flush", i), {31'd0, bus.exc_flush_all}, {31'd0, vecs[i].exp_flush});
            check($sformatf("v%0d_excaddr", i), bus.cp0_if_excaddr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            idle();
            check($sformatf("v%0d_icache", i), {31'd0, bus.exc_flush_icache}, {31'd0, vecs[i].exp_flush});
            rd(0, 5'd14, d); check($sformatf("v%0d_epc", i), d, vecs[i].exp_epc);
            rd(1, 5'd13, d); check($sformatf("v%0d_cause", i), d, vecs[i].exp_cause);
            rd(0, 5'd12, d); check($sformatf("v%0d_status", i), d, vecs[i].exp_status);
            rd(1, 5'd8, d);  check($sformatf("v%0d_badv", i), d, vecs[i].exp_badv);
        end

        // Unmapped register and disabled read port both return zero.
        rd(0, 5'd3, d); check("unmapped_read", d, 32'h0);
`ifndef CP0_TIMER_EN
        rd(1, 5'd9, d); check("count_absent", d, 32'h0);
`endif
        bus.ex_cp0_raddr = {5'd14, 5'd14};
        #1;
        check("re_off_read", bus.ex_cp0_rdata[31:0] | bus.ex_cp0_rdata[63:32], 32'h0);
        bus.ex_cp0_raddr = '0;

        // Hardware interrupt: SYNC_ST synchroniser flops plus the Cause register.
        bus.ex_cp0_exc_pc = {32'h0, 32'h00000100};
        bus.int_i = 6'b000001;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.exc_flush_all) begin
                n = k;
                break;
            end
        end
        check("int_latency", n, 32'd3);
        check("int_excaddr", bus.cp0_if_excaddr, 32'hBFC00380);
        @(posedge clk);
        #1;
        check("int_flush_drop", {31'd0, bus.exc_flush_all}, 32'd0);
        rd(0, 5'd14, d); check("int_epc", d, 32'h00000100);
        rd(1, 5'd13, d); check("int_cause", d, 32'h00000400);
        rd(0, 5'd12, d); check("int_status", d, 32'h0000FF03);
        bus.int_i = '0;

        // Asynchronous reset while an exception is being reported.
        bus.ex_cp0_exc_code = {5'h10, 5'h08};
        #1;
        check("pre_reset_flush", {31'd0, bus.exc_flush_all}, 32'd1);
        rst_ = 1'b0;
        #1;
        check("midrst_flush", {31'd0, bus.exc_flush_all}, 32'd0);
        check("midrst_icache", {31'd0, bus.exc_flush_icache}, 32'd0);
        check("midrst_excaddr", bus.cp0_if_excaddr, 32'h0);
        rd(0, 5'd12, d); check("midrst_status", d, 32'h0000FF01);
        rd(1, 5'd13, d); check("midrst_cause", d, 32'h0);
        rd(0, 5'd14, d); check("midrst_epc", d, 32'h0);
        idle();
        @(posedge clk);
        #1;
        rst_ = 1'b1;

`ifdef CP0_TIMER_EN
        // Count=0 and Compare=20 written together; TI after 20 increments at one per 2 cycles.
        bus.wb_cp0_we    = 2'b11;
        bus.wb_cp0_waddr = {5'd11, 5'd9};
        bus.wb_cp0_wdata = {32'd20, 32'd0};
        @(posedge clk);
        #1;
        idle();
        rd(0, 5'd9, d); check("timer_count_wr", d, 32'h0);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            rd(0, 5'd13, d);
            if (d[30]) begin
                n = k;
                break;
            end
        end
        check("timer_ti_window", {31'd0, (n == 40 || n == 41)}, 32'd1);
        check("timer_int_flush", {31'd0, bus.exc_flush_all}, 32'd1);
        check("timer_int_addr", bus.cp0_if_excaddr, 32'hBFC00380);
        bus.wb_cp0_we    = 2'b01;
        bus.wb_cp0_waddr = {5'd0, 5'd11};
        bus.wb_cp0_wdata = {32'd0, 32'd5};
        @(posedge clk);
        #1;
        idle();
        rd(0, 5'd13, d); check("timer_cause_code", {27'd0, d[6:2]}, 32'h0);
        rd(1, 5'd12, d); check("timer_exl", d, 32'h0000FF03);
        @(posedge clk);
        #1;
        rd(0, 5'd13, d); check("timer_ti_clear", {31'd0, d[30]}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
